// File: rtl/line_memory_ctrl.sv
// Line-granular backing store behind the L1 data cache.
// Services write-through writes and line-fill reads with fixed latencies,
// signals the cache through a busy/ready/done handshake and keeps
// saturating access counters for performance monitoring.
module line_memory_ctrl #(
   parameter int LINE_COUNT    = 256,
   parameter int READ_LATENCY  = 4,
   parameter int WRITE_LATENCY = 2,
   parameter int COUNT_W       = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               mem_read_req,
   input  logic [31:0]        mem_read_address,
   input  logic               mem_write,
   input  logic [31:0]        mem_write_address,
   input  logic [127:0]       mem_write_data,
   output logic               mem_busy,
   output logic               mem_ready,
   output logic [127:0]       mem_read_data,
   output logic               write_done,
   output logic [COUNT_W-1:0] rd_count,
   output logic [COUNT_W-1:0] wr_count
);

   localparam int IDX_W = $clog2(LINE_COUNT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t               state_r;
   state_t               state_s;
   logic                 accept_wr_s;
   logic                 accept_rd_s;
   logic                 wr_fire_s;
   logic                 rd_fire_s;
   logic                 cnt_zero_s;

   logic [31:0]          cnt_r;
   logic [IDX_W-1:0]     idx_r;
   logic [127:0]         data_r;
   logic [127:0]         mem_read_data_r;
   logic                 mem_busy_r;
   logic                 mem_ready_r;
   logic                 write_done_r;
   logic [COUNT_W-1:0]   rd_count_r;
   logic [COUNT_W-1:0]   wr_count_r;

   logic [127:0]         line_array [LINE_COUNT];

   // Offset bits and bits above the index select nothing: addresses wrap.
   logic                 unused_addr_bits_s;
   assign unused_addr_bits_s = ^{mem_read_address[31:IDX_W+4], mem_read_address[3:0],
                                 mem_write_address[31:IDX_W+4], mem_write_address[3:0]};

   // Saturating increment: the counter sticks at its all-ones value.
   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
      if (value == {COUNT_W{1'b1}}) begin
         sat_inc = value;
      end else begin
         sat_inc = value + {{(COUNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

   // Next-state and control strobes; writes win over a simultaneous read.
   always_comb begin
      state_s     = state_r;
      accept_wr_s = 1'b0;
      accept_rd_s = 1'b0;
      wr_fire_s   = 1'b0;
      rd_fire_s   = 1'b0;
      cnt_zero_s  = (cnt_r == 32'd0);
      case (state_r)
         IDLE: begin
            if (mem_write) begin
               accept_wr_s = 1'b1;
               state_s     = WRITE;
            end else if (mem_read_req) begin
               accept_rd_s = 1'b1;
               state_s     = READ;
            end else begin
               state_s     = IDLE;
            end
         end
         WRITE: begin
            if (cnt_zero_s) begin
               wr_fire_s = 1'b1;
               state_s   = DONE;
            end else begin
               state_s   = WRITE;
            end
         end
         READ: begin
            if (cnt_zero_s) begin
               rd_fire_s = 1'b1;
               state_s   = DONE;
            end else begin
               state_s   = READ;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, latency counter, captured request, registered outputs and counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r         <= IDLE;
         cnt_r           <= 32'd0;
         idx_r           <= {IDX_W{1'b0}};
         data_r          <= 128'd0;
         mem_read_data_r <= 128'd0;
         mem_busy_r      <= 1'b0;
         mem_ready_r     <= 1'b0;
         write_done_r    <= 1'b0;
         rd_count_r      <= {COUNT_W{1'b0}};
         wr_count_r      <= {COUNT_W{1'b0}};
      end else begin
         state_r      <= state_s;
         mem_busy_r   <= (state_s != IDLE);
         mem_ready_r  <= rd_fire_s;
         write_done_r <= wr_fire_s;
         if (accept_wr_s) begin
            idx_r      <= mem_write_address[IDX_W+3:4];
            data_r     <= mem_write_data;
            cnt_r      <= 32'(WRITE_LATENCY - 1);
            wr_count_r <= sat_inc(wr_count_r);
         end else if (accept_rd_s) begin
            idx_r      <= mem_read_address[IDX_W+3:4];
            cnt_r      <= 32'(READ_LATENCY - 1);
            rd_count_r <= sat_inc(rd_count_r);
         end else if (((state_r == WRITE) || (state_r == READ)) && !cnt_zero_s) begin
            cnt_r <= cnt_r - 32'd1;
         end else begin
            cnt_r <= cnt_r;
         end
         if (rd_fire_s) begin
            mem_read_data_r <= line_array[idx_r];
         end else begin
            mem_read_data_r <= mem_read_data_r;
         end
      end
   end

   // Line array: never reset, updated only when a write completes.
   always_ff @(posedge clk) begin
      if (wr_fire_s) begin
         line_array[idx_r] <= data_r;
      end
   end

   assign mem_busy      = mem_busy_r;
   assign mem_ready     = mem_ready_r;
   assign mem_read_data = mem_read_data_r;
   assign write_done    = write_done_r;
   assign rd_count      = rd_count_r;
   assign wr_count      = wr_count_r;

endmodule

// File: tb/tb_line_memory_ctrl.sv
// Directed self-checking bench for line_memory_ctrl (4-bit counters).
module tb_line_memory_ctrl;

   localparam int RL = 4;
   localparam int WL = 2;

   logic         clk;
   logic         reset;
   logic         mem_read_req;
   logic [31:0]  mem_read_address;
   logic         mem_write;
   logic [31:0]  mem_write_address;
   logic [127:0] mem_write_data;
   logic         mem_busy;
   logic         mem_ready;
   logic [127:0] mem_read_data;
   logic         write_done;
   logic [3:0]   rd_count;
   logic [3:0]   wr_count;

   int n_checks = 0;
   int n_fail   = 0;
   logic [3:0] exp_rd = 4'd0;
   logic [3:0] exp_wr = 4'd0;

   localparam logic [127:0] DATA_DB = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
   localparam logic [127:0] DATA_A  = 128'hAAAA_1111_2222_3333_4444_5555_6666_AAAA;
   localparam logic [127:0] DATA_B  = 128'hBBBB_9999_8888_7777_6666_5555_4444_BBBB;
   localparam logic [127:0] DATA_C  = 128'hC0C0_C1C1_C2C2_C3C3_C4C4_C5C5_C6C6_C7C7;
   localparam logic [127:0] DATA_D  = 128'h0D0D_F00D_0000_FFFF_1234_5678_9ABC_DEF0;
   localparam logic [127:0] DATA_E  = 128'hEEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE;

   typedef struct {
      logic         is_wr;
      logic [31:0]  addr;
      logic [127:0] data;
   } vec_t;

   vec_t vecs [8];

   line_memory_ctrl #(
      .LINE_COUNT(256), .READ_LATENCY(RL), .WRITE_LATENCY(WL), .COUNT_W(4)
   ) dut (
      .clk(clk), .reset(reset),
      .mem_read_req(mem_read_req), .mem_read_address(mem_read_address),
      .mem_write(mem_write), .mem_write_address(mem_write_address),
      .mem_write_data(mem_write_data),
      .mem_busy(mem_busy), .mem_ready(mem_ready), .mem_read_data(mem_read_data),
      .write_done(write_done), .rd_count(rd_count), .wr_count(wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] sat4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'h1;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [127:0] d);
      int lat;
      mem_write = 1'b1; mem_write_address = a; mem_write_data = d;
      tick;
      mem_write = 1'b0;
      exp_wr = sat4(exp_wr);
      check("wr_accept_busy", 128'(mem_busy), 128'd1);
      check("wr_count", 128'(wr_count), 128'(exp_wr));
      check("wr_rd_count", 128'(rd_count), 128'(exp_rd));
      lat = 0;
      while (!write_done && lat < 20) begin tick; lat++; end
      check("write_latency", 128'(lat), 128'(WL));
      check("wr_done_busy", 128'(mem_busy), 128'd1);
      tick;
      check("write_done_pulse", 128'(write_done), 128'd0);
      check("wr_idle_busy", 128'(mem_busy), 128'd0);
   endtask

   task automatic do_read(input logic [31:0] a, input logic [127:0] d);
      int lat;
      mem_read_req = 1'b1; mem_read_address = a;
      tick;
      mem_read_req = 1'b0;
      exp_rd = sat4(exp_rd);
      check("rd_accept_busy", 128'(mem_busy), 128'd1);
      check("rd_count", 128'(rd_count), 128'(exp_rd));
      check("rd_wr_count", 128'(wr_count), 128'(exp_wr));
      lat = 0;
      while (!mem_ready && lat < 20) begin tick; lat++; end
      check("read_latency", 128'(lat), 128'(RL));
      check("read_data", mem_read_data, d);
      tick;
      check("ready_pulse", 128'(mem_ready), 128'd0);
      check("read_data_hold", mem_read_data, d);
      check("rd_idle_busy", 128'(mem_busy), 128'd0);
   endtask

   task automatic pulse_reset;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      exp_rd = 4'd0; exp_wr = 4'd0;
      tick;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat;
      vecs[0] = '{1'b1, 32'h0000_0040, DATA_DB};
      vecs[1] = '{1'b0, 32'h0000_004C, DATA_DB};
      vecs[2] = '{1'b1, 32'h0000_1010, DATA_B};
      vecs[3] = '{1'b0, 32'h0000_0010, DATA_B};
      vecs[4] = '{1'b1, 32'h0000_03F0, DATA_C};
      vecs[5] = '{1'b0, 32'hFFFF_F3F8, DATA_C};
      vecs[6] = '{1'b1, 32'h0000_0FF0, DATA_D};
      vecs[7] = '{1'b0, 32'h0000_0FF0, DATA_D};

      reset = 1'b0; mem_read_req = 1'b0; mem_write = 1'b0;
      mem_read_address = 32'd0; mem_write_address = 32'd0; mem_write_data = 128'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 128'(mem_busy), 128'd0);
      check("rst_ready", 128'(mem_ready), 128'd0);
      check("rst_done", 128'(write_done), 128'd0);
      check("rst_data", mem_read_data, 128'd0);
      check("rst_counts", 128'({rd_count, wr_count}), 128'd0);
      reset = 1'b1;
      tick;

      // table: writes then reads, including address wrap and offset bits
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data);
         else               do_read(vecs[i].addr, vecs[i].data);
      end

      // simultaneous write and read to the same line: write first, read sees new data
      mem_write = 1'b1; mem_write_address = 32'h80; mem_write_data = DATA_A;
      mem_read_req = 1'b1; mem_read_address = 32'h80;
      tick;
      mem_write = 1'b0;
      exp_wr = sat4(exp_wr);
      check("sim_wr_count", 128'(wr_count), 128'(exp_wr));
      check("sim_rd_not_yet", 128'(rd_count), 128'(exp_rd));
      lat = 0;
      while (!write_done && lat < 20) begin tick; lat++; end
      check("sim_write_latency", 128'(lat), 128'(WL));
      tick;
      check("sim_rd_pending", 128'(rd_count), 128'(exp_rd));
      tick;
      mem_read_req = 1'b0;
      exp_rd = sat4(exp_rd);
      check("sim_rd_accept", 128'(rd_count), 128'(exp_rd));
      lat = 0;
      while (!mem_ready && lat < 20) begin tick; lat++; end
      check("sim_read_latency", 128'(lat), 128'(RL));
      check("sim_read_data", mem_read_data, DATA_A);
      tick;

      // requests while busy are ignored; a read held through ready is taken once after DONE
      mem_read_req = 1'b1; mem_read_address = 32'h40;
      tick;
      mem_read_req = 1'b0;
      exp_rd = sat4(exp_rd);
      mem_write = 1'b1; mem_write_address = 32'h200; mem_write_data = DATA_E;
      tick;
      check("busy_cnt_t1", 128'({rd_count, wr_count}), 128'({exp_rd, exp_wr}));
      mem_write = 1'b0; mem_read_req = 1'b1;
      tick;
      check("busy_cnt_t2", 128'({rd_count, wr_count}), 128'({exp_rd, exp_wr}));
      mem_read_req = 1'b0;
      tick;
      check("busy_cnt_t3", 128'({rd_count, wr_count}), 128'({exp_rd, exp_wr}));
      mem_read_req = 1'b1;
      tick;
      check("busy_ready", 128'(mem_ready), 128'd1);
      check("busy_data", mem_read_data, DATA_DB);
      check("busy_cnt_t4", 128'({rd_count, wr_count}), 128'({exp_rd, exp_wr}));
      tick;
      check("busy_done_idle", 128'(mem_busy), 128'd0);
      check("busy_no_double", 128'(rd_count), 128'(exp_rd));
      tick;
      mem_read_req = 1'b0;
      exp_rd = sat4(exp_rd);
      check("busy_extra_read", 128'(rd_count), 128'(exp_rd));
      lat = 0;
      while (!mem_ready && lat < 20) begin
         tick; lat++;
         check("busy_no_wdone", 128'(write_done), 128'd0);
      end
      check("busy_extra_latency", 128'(lat), 128'(RL));
      check("busy_extra_data", mem_read_data, DATA_DB);
      check("busy_wr_count", 128'(wr_count), 128'(exp_wr));
      tick;

      // reset two cycles into a read aborts it
      mem_read_req = 1'b1; mem_read_address = 32'h10;
      tick;
      mem_read_req = 1'b0;
      tick; tick;
      reset = 1'b0;
      #1;
      check("mid_rst_busy", 128'(mem_busy), 128'd0);
      check("mid_rst_data", mem_read_data, 128'd0);
      check("mid_rst_counts", 128'({rd_count, wr_count}), 128'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      exp_rd = 4'd0; exp_wr = 4'd0;
      lat = 0;
      for (int i = 0; i < 8; i++) begin
         tick;
         if (mem_ready || mem_busy) lat++;
      end
      check("mid_rst_no_ready", 128'(lat), 128'd0);
      do_read(32'h80, DATA_A);
      do_read(32'h0000_1010, DATA_B);

      // counter saturation
      pulse_reset;
      for (int i = 0; i < 17; i++) begin
         do_read(32'h10, DATA_B);
      end
      check("sat_rd_count", 128'(rd_count), 128'd15);
      check("sat_wr_count", 128'(wr_count), 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/line_memory_ctrl.md
Name: line_memory_ctrl

Overview:
- Backing-store controller directly downstream of the L1 data cache; services its line-fill reads and write-through writes.
- Holds a LINE_COUNT x 128-bit line array and models fixed read/write latency with a request/busy/ready handshake.
- Drives the cache's stall path through mem_busy and returns 128-bit lines on mem_ready.
- Keeps saturating read/write access counters for performance monitoring.

Parameters:
- LINE_COUNT, 256, number of 128-bit lines; power of two, >=2; index width IDX_W = clog2(LINE_COUNT).
- READ_LATENCY, 4, cycles from read acceptance to line load; >=1.
- WRITE_LATENCY, 2, cycles from write acceptance to array update; >=1.
- COUNT_W, 16, width of access counters.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- mem_read_req  input  1  line-fill request; held by requester until accepted.
- mem_read_address  input  32  byte address of the line to read.
- mem_write  input  1  write-through request; held until accepted.
- mem_write_address  input  32  byte address of the line to write.
- mem_write_data  input  128  line data to write.
- mem_busy  output  1  high whenever state != IDLE; requests are ignored while high.
- mem_ready  output  1  one-cycle pulse: mem_read_data is valid.
- mem_read_data  output  128  returned line; holds its value until the next read completes.
- write_done  output  1  one-cycle pulse: the array has been updated.
- rd_count  output  COUNT_W  accepted reads, saturating.
- wr_count  output  COUNT_W  accepted writes, saturating.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE; the latency counter and captured address/data clear.
  - Every output goes to 0, including mem_read_data, rd_count and wr_count.
  - Line array contents are not cleared.
  - A reset during READ/WRITE aborts the operation: no array update, no ready or done pulse.
- Addressing: line index = address[IDX_W+3:4]. Bits [3:0] are ignored. Bits above IDX_W+3 are ignored, so addresses wrap modulo LINE_COUNT lines.
- FSM states: IDLE, WRITE, READ, DONE. A 32-bit latency counter cnt is used in WRITE and READ.
- IDLE, at a rising edge:
  - If mem_write=1: capture write address and data; cnt <= WRITE_LATENCY-1; wr_count++; go to WRITE.
  - Else if mem_read_req=1: capture read address; cnt <= READ_LATENCY-1; rd_count++; go to READ.
  - A write takes priority when both requests are present; the read stays pending and is accepted on a later IDLE edge.
- WRITE:
  - If cnt=0: array[idx] <= captured data; write_done <= 1; go to DONE.
  - Else cnt--.
- READ:
  - If cnt=0: mem_read_data <= array[idx]; mem_ready <= 1; go to DONE.
  - Else cnt--.
- DONE: pulses clear (mem_ready, write_done <= 0); go to IDLE. mem_busy stays high, so a request still held during the pulse cycle is not accepted twice.
- Timing:
  - A read accepted at edge T gives mem_ready high from edge T+READ_LATENCY to T+READ_LATENCY+1.
  - The next request can be accepted at edge T+READ_LATENCY+2.
  - Writes follow the same pattern with WRITE_LATENCY.
  - mem_busy rises in the cycle after acceptance.
- Ordering: a read of a line that follows a write to the same line (including the same-cycle write-priority case) returns the new data.
- Counters: increment on acceptance only, and stick at 2^COUNT_W-1.
- No X propagation: mem_read_data changes only at read completion.

Test Plan:
- Write then read (READ_LATENCY=4, WRITE_LATENCY=2):
  - Write 128'hDEAD..BEEF to 0x0000_0040: write_done pulses 2 edges after acceptance.
  - Read 0x0000_004C: mem_ready pulses 4 edges after acceptance with data 128'hDEAD..BEEF.
  - mem_busy is high from acceptance through DONE.
- Simultaneous requests:
  - Assert mem_write (0x80, data A) and mem_read_req (0x80) together, both held.
  - Write is accepted first (wr_count=1). Read is accepted at the IDLE edge after DONE and returns A. rd_count=1.
- Requests while busy:
  - Start a read, then toggle mem_write and mem_read_req while mem_busy=1.
  - Counters unchanged, no extra pulses. Holding mem_read_req through the mem_ready cycle produces exactly one extra read, starting after DONE.
- Address wrap (LINE_COUNT=256):
  - Write data B to 0x0000_1010, then read 0x0000_0010: returns B (index 1).
- Reset mid-read:
  - Drive reset=0 two cycles into a READ.
  - All outputs go to 0 immediately. No mem_ready pulse follows. After release the FSM is in IDLE and previously written lines are intact.
- Counter saturation (COUNT_W=4):
  - Perform 17 reads: rd_count reads 15 after the 15th and stays 15; wr_count=0.
